imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage.
- Covers all five immediate formats: I, S, B, U and J.
- Sign-extends to XLEN and carries a caller tag alongside each result.
- Sits between fetch/decode and register read; a valid/ready handshake on both sides and a 2-entry output buffer decouple decode from stalls downstream.

---
 rtl/imm_gen_pipe.sv | 171 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the RV32I/RV64I decode stage. Takes
// instruction bits [31:7] plus a format select and produces the
// sign-extended immediate for the I, S, B, U and J formats. Each result
// travels with an opaque caller tag. A 2-entry FIFO sits on the output, so a
// stalled consumer does not immediately stall decode.
//
// Parameters:
//   XLEN   width of the extended immediate (32 or 64)
//   TAG_W  width of the tag carried with each request
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request this cycle (depends on count only)
//   instr      instruction bits [31:7]; bit 24 is instr[31]
//   sel        format: 000 I, 001 S, 010 B, 011 U, 100 J, others illegal
//   in_tag     tag for this request
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   imm_ext    extended immediate
//   out_tag    tag of this result
//   err        (IMM_ERR_EN only) the entry was pushed with an illegal sel
//
// Optional feature macro: IMM_ERR_EN
//   If it is defined, an err output is added and stored with each entry.
//   If it is not defined, an illegal sel gives imm_ext = 0 and no error
//   flag.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;

  // ---------------------------------------------------------------------------
  // Immediate formation. This is combinational on the request side only;
  // the outputs are always taken from the FIFO registers.
  // ---------------------------------------------------------------------------
  logic            w_sign;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;

  assign w_sign  = instr[24];

  assign w_imm_i = {{(XLEN-12){w_sign}}, instr[24:13]};
  assign w_imm_s = {{(XLEN-12){w_sign}}, instr[24:18], instr[4:0]};
  // B: imm[12] is instr[31], so it is part of the sign fill above bit 11.
  assign w_imm_b = {{(XLEN-12){w_sign}}, instr[0], instr[23:18], instr[4:1], 1'b0};
  // J: imm[20] is instr[31], so it is part of the sign fill above bit 19.
  assign w_imm_j = {{(XLEN-20){w_sign}}, instr[12:5], instr[13], instr[23:14], 1'b0};

  // U already fills bits 31:0. Sign bits exist only when XLEN is wider than 32.
  generate
    if (XLEN > 32) begin : g_u_wide
      assign w_imm_u = {{(XLEN-32){w_sign}}, instr[24:5], 12'b0};
    end else begin : g_u_narrow
      assign w_imm_u = {instr[24:5], 12'b0};
    end
  endgenerate

  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (sel)
      SEL_I:   w_imm = w_imm_i;
      SEL_S:   w_imm = w_imm_s;
      SEL_B:   w_imm = w_imm_b;
      SEL_U:   w_imm = w_imm_u;
      SEL_J:   w_imm = w_imm_j;
      default: w_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic             w_push;
  logic             w_pop;

  // in_ready is taken from count only, so there is no path from out_ready
  // back to the producer.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_imm[0] <= '0;
      r_imm[1] <= '0;
      r_tag[0] <= '0;
      r_tag[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_imm[r_wr_ptr] <= w_imm;
        r_tag[r_wr_ptr] <= in_tag;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign imm_ext = r_imm[r_rd_ptr];
  assign out_tag = r_tag[r_rd_ptr];

`ifdef IMM_ERR_EN
  logic r_err [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err[0] <= 1'b0;
      r_err[1] <= 1'b0;
    end else if (w_push) begin
      r_err[r_wr_ptr] <= w_illegal;
    end
  end

  assign err = out_valid & r_err[r_rd_ptr];
`else
  logic w_illegal_unused;
  assign w_illegal_unused = w_illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [24:0] instr;
  logic [2:0]  sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        in_ready64, out_valid64;
  logic [63:0] imm64;
  logic [7:0]  tag64;
`ifdef IMM_ERR_EN
  logic        err32, err64;
`endif

  int total;
  int bad;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .sel(sel), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32)
`ifdef IMM_ERR_EN
    , .err(err32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .sel(sel), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64)
`ifdef IMM_ERR_EN
    , .err(err64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step past the next rising edge. Inputs are then driven and outputs
  // checked 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset_valid32 got=%b exp=0", out_valid32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_ready32 got=%b exp=1", in_ready32); end
    total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL reset_imm32 got=%h exp=0", imm32); end
    total++; if (tag32 !== 8'h0) begin bad++; $display("FAIL reset_tag32 got=%h exp=0", tag32); end
    total++; if (imm64 !== 64'h0) begin bad++; $display("FAIL reset_imm64 got=%h exp=0", imm64); end
    total++; if (out_valid64 !== 1'b0) begin bad++; $display("FAIL reset_valid64 got=%b exp=0", out_valid64); end
  endtask

  task automatic test_i_type();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = {12'hFFC, 13'h0}; sel = 3'b000; in_tag = 8'h11;
    step();
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1) begin bad++; $display("FAIL i_valid got=%b exp=1", out_valid32); end
    total++; if (imm32 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL i_imm32 got=%h exp=fffffffc", imm32); end
    total++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL i_imm64 got=%h exp=fffffffffffffffc", imm64); end
    total++; if (tag32 !== 8'h11) begin bad++; $display("FAIL i_tag got=%h exp=11", tag32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL i_drain got=%b exp=0", out_valid32); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 25'b01000; sel = 3'b001; in_tag = 8'h21;
    step();
    instr = 25'b10000; sel = 3'b010; in_tag = 8'h22;
    total++; if (imm32 !== 32'h0000_0008) begin bad++; $display("FAIL s_imm got=%h exp=00000008", imm32); end
    total++; if (tag32 !== 8'h21) begin bad++; $display("FAIL s_tag got=%h exp=21", tag32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL s_ready got=%b exp=1", in_ready32); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1) begin bad++; $display("FAIL b_valid got=%b exp=1", out_valid32); end
    total++; if (imm32 !== 32'h0000_0010) begin bad++; $display("FAIL b_imm got=%h exp=00000010", imm32); end
    total++; if (tag32 !== 8'h22) begin bad++; $display("FAIL b_tag got=%h exp=22", tag32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL b_ready got=%b exp=1", in_ready32); end
    // Negative B offset: only f[24] and f[0] set -> imm[12] and imm[11] set, sign-filled.
    in_valid = 1'b1; instr = 25'h100_0001; sel = 3'b010; in_tag = 8'h23;
    step();
    in_valid = 1'b0;
    total++; if (imm32 !== 32'hFFFF_F800) begin bad++; $display("FAIL bneg_imm got=%h exp=fffff800", imm32); end
    step();
  endtask

  task automatic test_u_j();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = {20'h80000, 5'h0}; sel = 3'b011; in_tag = 8'h31;
    step();
    instr = 25'h000_2000; sel = 3'b100; in_tag = 8'h32;
    total++; if (imm64 !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL u_imm64 got=%h exp=ffffffff80000000", imm64); end
    total++; if (imm32 !== 32'h8000_0000) begin bad++; $display("FAIL u_imm32 got=%h exp=80000000", imm32); end
    step();
    // J with f[24] and f[12:5] set: imm[20] plus imm[19:12], sign-filled.
    instr = 25'h100_1FE0; sel = 3'b100; in_tag = 8'h33;
    total++; if (imm64 !== 64'h0000_0000_0000_0800) begin bad++; $display("FAIL j_imm64 got=%h exp=0000000000000800", imm64); end
    total++; if (tag64 !== 8'h32) begin bad++; $display("FAIL j_tag64 got=%h exp=32", tag64); end
    step();
    in_valid = 1'b0;
    total++; if (imm32 !== 32'hFFFF_F000) begin bad++; $display("FAIL jneg_imm32 got=%h exp=fffff000", imm32); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sel = 3'b000;
    in_valid = 1'b1; instr = {12'h001, 13'h0}; in_tag = 8'h01;
    step();
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready32); end
    instr = {12'h002, 13'h0}; in_tag = 8'h02;
    step();
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready32); end
    total++; if (tag32 !== 8'h01) begin bad++; $display("FAIL bp_hold got=%h exp=01", tag32); end
    instr = {12'h003, 13'h0}; in_tag = 8'h03;
    step();
    in_valid = 1'b0;
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b exp=0", in_ready32); end
    total++; if (imm32 !== 32'h1) begin bad++; $display("FAIL bp_stable got=%h exp=00000001", imm32); end
    out_ready = 1'b1;
    step();
    total++; if (tag32 !== 8'h02) begin bad++; $display("FAIL bp_pop2 got=%h exp=02", tag32); end
    total++; if (imm32 !== 32'h2) begin bad++; $display("FAIL bp_pop2_imm got=%h exp=00000002", imm32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0 (tag3 leaked?)", out_valid32); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 3'b000;
    in_valid = 1'b1; instr = {12'h041, 13'h0}; in_tag = 8'h41;
    step();
    instr = {12'h042, 13'h0}; in_tag = 8'h42;
    step();
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL rm_full got=%b exp=0", in_ready32); end
    // Reset wins over a concurrent push and pop.
    rst = 1'b1; out_ready = 1'b1; instr = {12'h043, 13'h0}; in_tag = 8'h43;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid32); end
    total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL rm_imm got=%h exp=0", imm32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", in_ready32); end
    total++; if (tag32 !== 8'h0) begin bad++; $display("FAIL rm_tag got=%h exp=0", tag32); end
    in_valid = 1'b1; instr = {12'h005, 13'h0}; in_tag = 8'h55;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (tag32 !== 8'h55) begin bad++; $display("FAIL rm_new_tag got=%h exp=55", tag32); end
    total++; if (imm32 !== 32'h5) begin bad++; $display("FAIL rm_new_imm got=%h exp=00000005", imm32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL rm_no_stale got=%b exp=0", out_valid32); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 25'h1FF_FFFF; sel = 3'b111; in_tag = 8'h61;
    step();
    sel = 3'b000; in_tag = 8'h62;
    total++; if (out_valid32 !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b exp=1", out_valid32); end
    total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL ill_imm32 got=%h exp=0", imm32); end
    total++; if (imm64 !== 64'h0) begin bad++; $display("FAIL ill_imm64 got=%h exp=0", imm64); end
    total++; if (tag32 !== 8'h61) begin bad++; $display("FAIL ill_tag got=%h exp=61", tag32); end
`ifdef IMM_ERR_EN
    total++; if (err32 !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err32); end
`endif
    step();
    in_valid = 1'b0;
    total++; if (imm32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL legal_after_imm got=%h exp=ffffffff", imm32); end
    total++; if (tag32 !== 8'h62) begin bad++; $display("FAIL legal_after_tag got=%h exp=62", tag32); end
`ifdef IMM_ERR_EN
    total++; if (err32 !== 1'b0) begin bad++; $display("FAIL legal_after_err got=%b exp=0", err32); end
`endif
    step();
`ifdef IMM_ERR_EN
    total++; if (err32 !== 1'b0) begin bad++; $display("FAIL err_idle got=%b exp=0", err32); end
`endif
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL ill_drain got=%b exp=0", out_valid32); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; instr = '0; sel = '0; in_tag = '0; out_ready = 1'b0;
    test_reset();
    test_i_type();
    test_back_to_back();
    test_u_j();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
